// File: rtl/sobel_window_gen.sv
// sobel_window_gen: turns a raster pixel stream into 3x3 neighbourhood windows for the sobel stage
module sobel_window_gen #(
  parameter int WIDTH  = 720,
  parameter int HEIGHT = 540,
  parameter int DWIDTH = 8
) (
  input  logic                clock,
  input  logic                reset,
  output logic                fifo_in_rd_en,
  input  logic [DWIDTH-1:0]   fifo_in_dout,
  input  logic                fifo_in_empty,
  output logic                fifo_out_wr_en,
  output logic [9*DWIDTH-1:0] fifo_out_din,
  input  logic                fifo_out_full,
  output logic                frame_done
);
  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);
  logic [DWIDTH-1:0]   lb0 [WIDTH];
  logic [DWIDTH-1:0]   lb1 [WIDTH];
  logic [3*DWIDTH-1:0] top, mid, bot, top_n, mid_n, bot_n;
  logic [CW-1:0]       col;
  logic [RW-1:0]       row;
  logic                pending, last, accept, load, last_col, last_row;
  // handshake, position decode and the window after shifting in the new column
  always_comb begin
    accept         = !reset && !fifo_in_empty && !(pending && fifo_out_full);
    fifo_in_rd_en  = accept;
    fifo_out_wr_en = pending && !fifo_out_full;
    frame_done     = fifo_out_wr_en && last;
    last_col       = col == CW'(WIDTH - 1);
    last_row       = row == RW'(HEIGHT - 1);
    load           = accept && row >= RW'(2) && col >= CW'(2);
    top_n          = {top[2*DWIDTH-1:0], lb0[col]};
    mid_n          = {mid[2*DWIDTH-1:0], lb1[col]};
    bot_n          = {bot[2*DWIDTH-1:0], fifo_in_dout};
  end
  // line buffers and window shift registers carry no reset; only valid contents are ever emitted
  always_ff @(posedge clock) begin
    if (accept) begin
      lb0[col] <= lb1[col];
      lb1[col] <= fifo_in_dout;
      top      <= top_n;
      mid      <= mid_n;
      bot      <= bot_n;
    end
  end
  // raster counters and the output holding register; a load wins over a push so windows stream back to back
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      col          <= '0;
      row          <= '0;
      pending      <= 1'b0;
      last         <= 1'b0;
      fifo_out_din <= '0;
    end else begin
      if (accept) begin
        col <= last_col ? '0 : col + CW'(1);
        row <= last_col ? (last_row ? '0 : row + RW'(1)) : row;
      end
      if (load) begin
        fifo_out_din <= {top_n, mid_n, bot_n};
        pending      <= 1'b1;
        last         <= last_col && last_row;
      end else if (fifo_out_wr_en) begin
        pending <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_sobel_window_gen.sv
// tb_sobel_window_gen: directed checks of window extraction, stalls, gaps, frame wrap and mid-frame reset
module tb_sobel_window_gen;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        fifo_in_rd_en;
  logic [7:0]  fifo_in_dout = '0;
  logic        fifo_in_empty = 1'b1;
  logic        fifo_out_wr_en;
  logic [71:0] fifo_out_din;
  logic        fifo_out_full = 1'b0;
  logic        frame_done;
  int          checks = 0;
  int          errors = 0;
  int          idx = 0;
  int          cyc = 0;
  int          fd_cnt = 0;
  int          acc_cyc = -1;
  int          push_cyc = -1;
  logic        viol = 1'b0;
  logic        s_rd;
  logic [71:0] s_din;
  logic [71:0] got [$];
  logic        fd [$];

  sobel_window_gen #(.WIDTH(5), .HEIGHT(4), .DWIDTH(8)) dut (
    .clock          (clock),
    .reset          (reset),
    .fifo_in_rd_en  (fifo_in_rd_en),
    .fifo_in_dout   (fifo_in_dout),
    .fifo_in_empty  (fifo_in_empty),
    .fifo_out_wr_en (fifo_out_wr_en),
    .fifo_out_din   (fifo_out_din),
    .fifo_out_full  (fifo_out_full),
    .frame_done     (frame_done)
  );

  always #5 clock = ~clock;

  // pixel idx of the stream: frame 0 is 16*r+c, frame 1 adds 0x80
  function automatic logic [7:0] pix(input int i);
    int k;
    k = i % 20;
    return 8'(((i >= 20) ? 128 : 0) + 16 * (k / 5) + k % 5);
  endfunction

  // expected window centred-bottom-right at (r,c), row-major with top-left in the MSBs
  function automatic logic [71:0] exp_win(input logic [7:0] base, input int r, input int c);
    logic [71:0] w;
    w = '0;
    for (int dr = 0; dr < 3; dr++)
      for (int dc = 0; dc < 3; dc++)
        w = {w[63:0], 8'(base + 16 * (r - 2 + dr) + (c - 2 + dc))};
    return w;
  endfunction

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // one clock: drive inputs, sample combinational outputs, model the FWFT source, then cross the edge
  task automatic tick(input logic e, input logic f);
    fifo_in_empty = e;
    fifo_out_full = f;
    fifo_in_dout  = pix(idx);
    #1;
    s_rd  = fifo_in_rd_en;
    s_din = fifo_out_din;
    if (s_rd && e) viol = 1'b1;
    if (fifo_out_wr_en) begin
      got.push_back(fifo_out_din);
      fd.push_back(frame_done);
      if (push_cyc < 0) push_cyc = cyc;
    end
    if (frame_done) fd_cnt++;
    if (s_rd) begin
      if (idx == 12 && acc_cyc < 0) acc_cyc = cyc;
      idx++;
    end
    @(posedge clock);
    #2;
    cyc++;
  endtask

  task automatic start();
    reset         = 1'b1;
    fifo_in_empty = 1'b1;
    fifo_out_full = 1'b0;
    idx           = 0;
    fd_cnt        = 0;
    acc_cyc       = -1;
    push_cyc      = -1;
    viol          = 1'b0;
    got.delete();
    fd.delete();
    repeat (2) @(posedge clock);
    #2;
    reset = 1'b0;
  endtask

  task automatic run_to(input int target, input int pct_empty);
    int n;
    n = 0;
    while (idx < target && n < 400) begin
      tick(logic'($urandom_range(0, 99) < pct_empty), 1'b0);
      n++;
    end
  endtask

  task automatic drain();
    repeat (4) tick(1'b1, 1'b0);
  endtask

  task automatic check_frame(input string tag, input int start_at, input logic [7:0] base);
    for (int k = 0; k < 6; k++)
      if (start_at + k < got.size()) begin
        chk($sformatf("%s_win%0d", tag, start_at + k), got[start_at + k], exp_win(base, 2 + k / 3, 2 + k % 3));
        chk($sformatf("%s_done%0d", tag, start_at + k), 72'(fd[start_at + k]), 72'(k == 5));
      end
  endtask

  initial begin
    fifo_in_empty = 1'b0;
    #12;
    chk("rst_rd_en", 72'(fifo_in_rd_en), 72'd0);
    chk("rst_wr_en", 72'(fifo_out_wr_en), 72'd0);
    chk("rst_din", fifo_out_din, 72'd0);
    chk("rst_frame_done", 72'(frame_done), 72'd0);

    start();
    run_to(20, 0);
    drain();
    chk("s1_count", 72'(got.size()), 72'd6);
    chk("s1_first", (got.size() > 0) ? got[0] : '0, 72'h00_01_02_10_11_12_20_21_22);
    chk("s1_last", (got.size() > 5) ? got[5] : '0, 72'h12_13_14_22_23_24_32_33_34);
    check_frame("s1", 0, 8'h00);
    chk("s1_done_pulses", 72'(fd_cnt), 72'd1);
    chk("s1_latency", 72'(push_cyc - acc_cyc), 72'd1);

    start();
    for (int n = 0; n < 100 && got.size() < 1; n++) tick(1'b0, 1'b0);
    for (int n = 0; n < 10; n++) begin
      tick(1'b0, 1'b1);
      chk($sformatf("s2_stall_rd%0d", n), 72'(s_rd), 72'd0);
      chk($sformatf("s2_stall_din%0d", n), s_din, exp_win(8'h00, 2, 3));
    end
    run_to(20, 0);
    drain();
    chk("s2_count", 72'(got.size()), 72'd6);
    check_frame("s2", 0, 8'h00);

    start();
    run_to(20, 50);
    drain();
    chk("s3_rd_while_empty", 72'(viol), 72'd0);
    chk("s3_count", 72'(got.size()), 72'd6);
    check_frame("s3", 0, 8'h00);

    start();
    run_to(40, 0);
    drain();
    chk("s4_count", 72'(got.size()), 72'd12);
    check_frame("s4a", 0, 8'h00);
    check_frame("s4b", 6, 8'h80);
    chk("s4_done_pulses", 72'(fd_cnt), 72'd2);

    start();
    run_to(14, 0);
    chk("s5_pending_before", 72'(fifo_out_wr_en), 72'd1);
    fifo_in_empty = 1'b0;
    fifo_out_full = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    chk("s5_rst_wr_en", 72'(fifo_out_wr_en), 72'd0);
    chk("s5_rst_din", fifo_out_din, 72'd0);
    chk("s5_rst_frame_done", 72'(frame_done), 72'd0);
    chk("s5_rst_rd_en", 72'(fifo_in_rd_en), 72'd0);
    chk("s5_count_before", 72'(got.size()), 72'd1);
    start();
    run_to(20, 0);
    drain();
    chk("s5_count_after", 72'(got.size()), 72'd6);
    check_frame("s5", 0, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
